// File: rtl/raster_scan_array_pkg.sv
// raster_pkg: shared types and helpers for the raster_scan_array triangle scan engine.
// Holds the edge accumulator width rule, the scan FSM state encoding, the
// edge coefficient bundle and the coverage test used by every lane.
package raster_pkg;

  // Default coordinate width the package-level types are sized for.
  localparam int PKG_COORD_W = 16;

  // Edge accumulators carry two extra bits over a full a*x + b*y product so
  // that summing three in-range terms can never overflow.
  function automatic int acc_width(input int coord_w);
    return 2 * coord_w + 2;
  endfunction

  localparam int ACC_W = acc_width(PKG_COORD_W);

  typedef logic signed [ACC_W-1:0] edge_acc_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_t;

  typedef struct packed {
    edge_acc_t a;
    edge_acc_t b;
    edge_acc_t c;
  } edge_set_t;

  // A pixel is inside when all three edge values share a sign, which makes
  // the engine insensitive to triangle winding order.
  function automatic logic is_covered(input logic [2:0] sign_bits);
    return (sign_bits == 3'b000) || (sign_bits == 3'b111);
  endfunction

endpackage

// File: rtl/raster_scan_array_edge_walker.sv
// edge_walker: one scan lane's incremental evaluation of three edge functions.
// Loads its row-start values in SETUP, steps +a per pixel, jumps a whole lane
// group down at the end of each row, and holds while the array is stalled.
module edge_walker
  import raster_pkg::*;
#(
  parameter int ACC_WIDTH = 34,
  parameter int LANE      = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_load,
  input  logic                        i_step,
  input  logic                        i_row_wrap,
  input  logic signed [ACC_WIDTH-1:0] i_e0    [3],
  input  logic signed [ACC_WIDTH-1:0] i_a     [3],
  input  logic signed [ACC_WIDTH-1:0] i_b     [3],
  input  logic signed [ACC_WIDTH-1:0] i_bstep [3],
  output logic                        o_covered
);

  localparam logic signed [ACC_WIDTH-1:0] LANE_OFS = ACC_WIDTH'(LANE);

  logic signed [ACC_WIDTH-1:0] r_e   [3];
  logic signed [ACC_WIDTH-1:0] r_row [3];
  logic [2:0]                  w_signs;

  // Edge and row-start accumulators: load lane offset, step in x, wrap rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        r_e[k]   <= '0;
        r_row[k] <= '0;
      end
    end else if (i_load) begin
      for (int k = 0; k < 3; k++) begin
        r_e[k]   <= i_e0[k] + i_b[k] * LANE_OFS;
        r_row[k] <= i_e0[k] + i_b[k] * LANE_OFS;
      end
    end else if (i_step) begin
      for (int k = 0; k < 3; k++) begin
        if (i_row_wrap) begin
          r_e[k]   <= r_row[k] + i_bstep[k];
          r_row[k] <= r_row[k] + i_bstep[k];
        end else begin
          r_e[k]   <= r_e[k] + i_a[k];
        end
      end
    end
  end

  // Gather the three edge sign bits for the coverage test.
  always_comb begin
    w_signs = 3'b000;
    for (int k = 0; k < 3; k++) begin
      w_signs[k] = r_e[k][ACC_WIDTH-1];
    end
  end

  assign o_covered = is_covered(w_signs);

endmodule

// File: rtl/raster_scan_array.sv
// raster_scan_array: multi-lane triangle scan engine.
// Walks the clipped bbox in groups of CORES_COUNT rows, one x step per cycle,
// and emits covered pixels with framebuffer addresses over per-lane
// valid/ready. Any lane holding an unaccepted pixel freezes the whole array.
// Optional feature: define PIXEL_COUNT_EN to add the covered_count output.
module raster_scan_array
  import raster_pkg::*;
#(
  parameter int COORD_WIDTH   = 16,
  parameter int COLOR_WIDTH   = 16,
  parameter int SCREEN_X_SIZE = 800,
  parameter int SCREEN_Y_SIZE = 600,
  parameter int CORES_COUNT   = 10,
  parameter int BUFFER_ADDR_W = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic signed [COORD_WIDTH-1:0]   edge_a [3],
  input  logic signed [COORD_WIDTH-1:0]   edge_b [3],
  input  logic signed [2*COORD_WIDTH-1:0] edge_c [3],
  input  logic [COORD_WIDTH-1:0]          bbox_x_min,
  input  logic [COORD_WIDTH-1:0]          bbox_x_max,
  input  logic [COORD_WIDTH-1:0]          bbox_y_min,
  input  logic [COORD_WIDTH-1:0]          bbox_y_max,
  input  logic [BUFFER_ADDR_W-1:0]        fb_base,
  input  logic [COLOR_WIDTH-1:0]          color,
  output logic [CORES_COUNT-1:0]          out_valid,
  input  logic [CORES_COUNT-1:0]          out_ready,
  output logic [COLOR_WIDTH-1:0]          out_data    [CORES_COUNT],
  output logic [BUFFER_ADDR_W-1:0]        out_address [CORES_COUNT]
`ifdef PIXEL_COUNT_EN
  , output logic [31:0]                   covered_count
`endif
);

  localparam int EACC_W = acc_width(COORD_WIDTH);
  localparam int YW     = COORD_WIDTH + $clog2(CORES_COUNT + 1) + 1;
  localparam logic [COORD_WIDTH-1:0]   X_LAST       = COORD_WIDTH'(SCREEN_X_SIZE - 1);
  localparam logic [COORD_WIDTH-1:0]   Y_LAST       = COORD_WIDTH'(SCREEN_Y_SIZE - 1);
  localparam logic [BUFFER_ADDR_W-1:0] GROUP_STRIDE = BUFFER_ADDR_W'(SCREEN_X_SIZE * CORES_COUNT);
  localparam logic [YW-1:0]            GROUP_ROWS   = YW'(CORES_COUNT);

  scan_state_t                r_state;
  logic                       r_busy;
  logic                       r_done;
  logic signed [EACC_W-1:0]   r_a     [3];
  logic signed [EACC_W-1:0]   r_b     [3];
  logic signed [EACC_W-1:0]   r_c     [3];
  logic signed [EACC_W-1:0]   r_bstep [3];
  logic [COORD_WIDTH-1:0]     r_x_min;
  logic [COORD_WIDTH-1:0]     r_x_max;
  logic [COORD_WIDTH-1:0]     r_y_min;
  logic [COORD_WIDTH-1:0]     r_y_max;
  logic [COORD_WIDTH-1:0]     r_x;
  logic [YW-1:0]              r_y_grp;
  logic [BUFFER_ADDR_W-1:0]   r_fb_base;
  logic [BUFFER_ADDR_W-1:0]   r_row_addr;
  logic [COLOR_WIDTH-1:0]     r_color;
  logic [CORES_COUNT-1:0]     r_out_valid;
  logic [COLOR_WIDTH-1:0]     r_out_data    [CORES_COUNT];
  logic [BUFFER_ADDR_W-1:0]   r_out_address [CORES_COUNT];

  logic signed [EACC_W-1:0]   w_e0    [3];
  logic signed [EACC_W-1:0]   w_bstep [3];
  logic [COORD_WIDTH-1:0]     w_x_max_c;
  logic [COORD_WIDTH-1:0]     w_y_max_c;
  logic                       w_empty;
  logic                       w_stall;
  logic                       w_load;
  logic                       w_step;
  logic                       w_row_wrap;
  logic                       w_last_group;
  logic [CORES_COUNT-1:0]     w_covered;
  logic [CORES_COUNT-1:0]     w_lane_en;
  logic [BUFFER_ADDR_W-1:0]   w_lane_addr [CORES_COUNT];

  // Clamp the box to the screen and derive the first-row edge values.
  always_comb begin
    w_x_max_c = (r_x_max > X_LAST) ? X_LAST : r_x_max;
    w_y_max_c = (r_y_max > Y_LAST) ? Y_LAST : r_y_max;
    w_empty   = (r_x_min > w_x_max_c) || (r_y_min > w_y_max_c);
    for (int e = 0; e < 3; e++) begin
      w_e0[e]    = r_a[e] * $signed(EACC_W'(r_x_min))
                 + r_b[e] * $signed(EACC_W'(r_y_min))
                 + r_c[e];
      w_bstep[e] = r_b[e] * $signed(EACC_W'(CORES_COUNT));
    end
  end

  assign w_stall      = |(r_out_valid & ~out_ready);
  assign w_load       = (r_state == ST_SETUP);
  assign w_step       = (r_state == ST_SCAN) && !w_stall;
  assign w_row_wrap   = (r_x == r_x_max);
  assign w_last_group = (r_y_grp + GROUP_ROWS) > YW'(r_y_max);

  for (genvar i = 0; i < CORES_COUNT; i++) begin : g_lane
    edge_walker #(
      .ACC_WIDTH (EACC_W),
      .LANE      (i)
    ) u_walker (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_step     (w_step),
      .i_row_wrap (w_row_wrap),
      .i_e0       (w_e0),
      .i_a        (r_a),
      .i_b        (r_b),
      .i_bstep    (r_bstep),
      .o_covered  (w_covered[i])
    );
    assign w_lane_en[i]   = (r_y_grp + YW'(i)) <= YW'(r_y_max);
    assign w_lane_addr[i] = r_row_addr + BUFFER_ADDR_W'(i * SCREEN_X_SIZE) + BUFFER_ADDR_W'(r_x);
  end

  // Job sequencing: latch inputs, set up the walk, scan, drain, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_x_min    <= '0;
      r_x_max    <= '0;
      r_y_min    <= '0;
      r_y_max    <= '0;
      r_x        <= '0;
      r_y_grp    <= '0;
      r_fb_base  <= '0;
      r_row_addr <= '0;
      r_color    <= '0;
      for (int e = 0; e < 3; e++) begin
        r_a[e]     <= '0;
        r_b[e]     <= '0;
        r_c[e]     <= '0;
        r_bstep[e] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int e = 0; e < 3; e++) begin
              r_a[e] <= EACC_W'(edge_a[e]);
              r_b[e] <= EACC_W'(edge_b[e]);
              r_c[e] <= EACC_W'(edge_c[e]);
            end
            r_x_min   <= bbox_x_min;
            r_x_max   <= bbox_x_max;
            r_y_min   <= bbox_y_min;
            r_y_max   <= bbox_y_max;
            r_fb_base <= fb_base;
            r_color   <= color;
            r_busy    <= 1'b1;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_x_max    <= w_x_max_c;
          r_y_max    <= w_y_max_c;
          r_x        <= r_x_min;
          r_y_grp    <= YW'(r_y_min);
          r_row_addr <= r_fb_base + BUFFER_ADDR_W'(r_y_min) * BUFFER_ADDR_W'(SCREEN_X_SIZE);
          for (int e = 0; e < 3; e++) begin
            r_bstep[e] <= w_bstep[e];
          end
          if (w_empty) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!w_stall) begin
            if (w_row_wrap) begin
              r_x        <= r_x_min;
              r_y_grp    <= r_y_grp + GROUP_ROWS;
              r_row_addr <= r_row_addr + GROUP_STRIDE;
              if (w_last_group) begin
                r_state <= ST_DRAIN;
              end
            end else begin
              r_x <= r_x + COORD_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!w_stall) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Lane output registers: load a new step when not stalled, else retire accepted lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= '0;
      for (int i = 0; i < CORES_COUNT; i++) begin
        r_out_data[i]    <= '0;
        r_out_address[i] <= '0;
      end
    end else if (w_step) begin
      r_out_valid <= w_covered & w_lane_en;
      for (int i = 0; i < CORES_COUNT; i++) begin
        r_out_data[i]    <= r_color;
        r_out_address[i] <= w_lane_addr[i];
      end
    end else begin
      r_out_valid <= r_out_valid & ~out_ready;
    end
  end

`ifdef PIXEL_COUNT_EN
  logic [31:0] r_covered_count;
  logic [31:0] w_accept_cnt;

  // Number of lanes handing over a pixel this cycle.
  always_comb begin
    w_accept_cnt = 32'd0;
    for (int i = 0; i < CORES_COUNT; i++) begin
      w_accept_cnt = w_accept_cnt + {31'd0, r_out_valid[i] & out_ready[i]};
    end
  end

  // Running total of accepted pixels, cleared when a new job is set up.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_covered_count <= 32'd0;
    end else if (r_state == ST_SETUP) begin
      r_covered_count <= 32'd0;
    end else begin
      r_covered_count <= r_covered_count + w_accept_cnt;
    end
  end

  assign covered_count = r_covered_count;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_address = r_out_address;

endmodule

// File: tb/tb_raster_scan_array.sv
// Testbench for raster_scan_array on an 8x8 screen with 4 lanes.
// Directed jobs from the test plan followed by randomized triangles, all
// checked against a per-pixel edge-function model of the whole screen.
module tb_raster_scan_array;

  localparam int CW = 16;
  localparam int COLW = 16;
  localparam int SX = 8;
  localparam int SY = 8;
  localparam int NC = 4;
  localparam int AW = 32;

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic signed [CW-1:0]   edge_a [3];
  logic signed [CW-1:0]   edge_b [3];
  logic signed [2*CW-1:0] edge_c [3];
  logic [CW-1:0]          bbox_x_min;
  logic [CW-1:0]          bbox_x_max;
  logic [CW-1:0]          bbox_y_min;
  logic [CW-1:0]          bbox_y_max;
  logic [AW-1:0]          fb_base;
  logic [COLW-1:0]        color;
  logic [NC-1:0]          out_valid;
  logic [NC-1:0]          out_ready;
  logic [COLW-1:0]        out_data    [NC];
  logic [AW-1:0]          out_address [NC];
`ifdef PIXEL_COUNT_EN
  logic [31:0]            covered_count;
`endif

  raster_scan_array #(
    .COORD_WIDTH   (CW),
    .COLOR_WIDTH   (COLW),
    .SCREEN_X_SIZE (SX),
    .SCREEN_Y_SIZE (SY),
    .CORES_COUNT   (NC),
    .BUFFER_ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .edge_a      (edge_a),
    .edge_b      (edge_b),
    .edge_c      (edge_c),
    .bbox_x_min  (bbox_x_min),
    .bbox_x_max  (bbox_x_max),
    .bbox_y_min  (bbox_y_min),
    .bbox_y_max  (bbox_y_max),
    .fb_base     (fb_base),
    .color       (color),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_address (out_address)
`ifdef PIXEL_COUNT_EN
    , .covered_count (covered_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Job description (reference side)
  int ea [3];
  int eb [3];
  int ec [3];
  int jx0, jx1, jy0, jy1;
  logic [AW-1:0]   jfb;
  logic [COLW-1:0] jcol;

  // Scoreboard of accepted pixels
  int            hit [SX*SY];
  int            accepted;
  int            bad_addr;
  int            bad_data;
  int            bad_lane;
  logic [NC-1:0] lane_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_inside_tri(input int x, input int y);
    longint e;
    int pos;
    int neg;
    pos = 0;
    neg = 0;
    for (int k = 0; k < 3; k++) begin
      e = longint'(ea[k]) * x + longint'(eb[k]) * y + longint'(ec[k]);
      if (e >= 0) pos++;
      else neg++;
    end
    return (pos == 3) || (neg == 3);
  endfunction

  function automatic bit model_pixel(input int x, input int y);
    int xm;
    int ym;
    xm = (jx1 > SX - 1) ? SX - 1 : jx1;
    ym = (jy1 > SY - 1) ? SY - 1 : jy1;
    return (x >= jx0) && (x <= xm) && (y >= jy0) && (y <= ym) && model_inside_tri(x, y);
  endfunction

  function automatic int model_duration();
    int xm;
    int ym;
    xm = (jx1 > SX - 1) ? SX - 1 : jx1;
    ym = (jy1 > SY - 1) ? SY - 1 : jy1;
    if (jx0 > xm || jy0 > ym) return 3;
    return 4 + (xm - jx0 + 1) * ((ym - jy0 + NC) / NC);
  endfunction

  task automatic apply_job();
    for (int k = 0; k < 3; k++) begin
      edge_a[k] = CW'(ea[k]);
      edge_b[k] = CW'(eb[k]);
      edge_c[k] = (2*CW)'(ec[k]);
    end
    bbox_x_min = CW'(jx0);
    bbox_x_max = CW'(jx1);
    bbox_y_min = CW'(jy0);
    bbox_y_max = CW'(jy1);
    fb_base    = jfb;
    color      = jcol;
  endtask

  task automatic run_job(input string tag, input int stall_lane, input int stall_from,
                         input int stall_len, input bit rnd_ready);
    bit            got;
    int            dur;
    int            y;
    int            exp_total;
    int            mism;
    logic [AW-1:0] off;
    logic [AW-1:0] cap_addr;
    logic [COLW-1:0] cap_data;
    logic [NC-1:0] exp_lanes;
    apply_job();
    for (int p = 0; p < SX*SY; p++) hit[p] = 0;
    accepted = 0; bad_addr = 0; bad_data = 0; bad_lane = 0; lane_seen = '0;
    cap_addr = '0; cap_data = '0;
    got = 1'b0;
    dur = -1;
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1) start = 1'b0;
      for (int i = 0; i < NC; i++) out_ready[i] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_lane >= 0 && k >= stall_from && k < stall_from + stall_len) out_ready[stall_lane] = 1'b0;
      @(negedge clk);
      if (k == 1) chk({tag, "_busy_setup"}, 64'(busy), 64'd1);
      if (stall_lane >= 0 && k == stall_from) begin
        cap_addr = out_address[stall_lane];
        cap_data = out_data[stall_lane];
      end
      if (stall_lane >= 0 && k == stall_from + stall_len - 1) begin
        chk({tag, "_stall_addr"}, 64'(out_address[stall_lane]), 64'(cap_addr));
        chk({tag, "_stall_data"}, 64'(out_data[stall_lane]), 64'(cap_data));
        chk({tag, "_stall_valid"}, 64'(out_valid[stall_lane]), 64'd1);
      end
      for (int i = 0; i < NC; i++) begin
        if (out_valid[i] === 1'b1) begin
          lane_seen[i] = 1'b1;
          if (out_ready[i]) begin
            accepted++;
            off = out_address[i] - jfb;
            if (off < AW'(SX*SY)) begin
              hit[off]++;
              y = int'(off) / SX;
              if (y < jy0 || ((y - jy0) % NC) != i) bad_lane++;
            end else begin
              bad_addr++;
            end
            if (out_data[i] !== jcol) bad_data++;
          end
        end
      end
      if (done === 1'b1) begin
        got = 1'b1;
        dur = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = '1;
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    mism = 0;
    exp_total = 0;
    exp_lanes = '0;
    for (int yy = 0; yy < SY; yy++) begin
      for (int xx = 0; xx < SX; xx++) begin
        if (model_pixel(xx, yy)) begin
          exp_total++;
          exp_lanes[(yy - jy0) % NC] = 1'b1;
        end
        if (hit[yy*SX + xx] != (model_pixel(xx, yy) ? 1 : 0)) mism++;
      end
    end
    chk({tag, "_pixel_set"}, 64'(mism), 64'd0);
    chk({tag, "_accepted"}, 64'(accepted), 64'(exp_total));
    chk({tag, "_bad_addr"}, 64'(bad_addr), 64'd0);
    chk({tag, "_bad_data"}, 64'(bad_data), 64'd0);
    chk({tag, "_bad_lane"}, 64'(bad_lane), 64'd0);
    chk({tag, "_lanes_seen"}, 64'(lane_seen), 64'(exp_lanes));
    if (!rnd_ready) chk({tag, "_duration"}, 64'(dur), 64'(model_duration() + stall_len));
`ifdef PIXEL_COUNT_EN
    chk({tag, "_covered_count"}, 64'(covered_count), 64'(exp_total));
`endif
  endtask

  task automatic set_flat(input int c0);
    for (int k = 0; k < 3; k++) begin
      ea[k] = 0;
      eb[k] = 0;
      ec[k] = c0;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = '1;
    set_flat(1);
    jx0 = 0; jx1 = 7; jy0 = 0; jy1 = 7;
    jfb = 32'h0000_1000;
    jcol = 16'hABCD;
    apply_job();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < NC; i++) begin
      chk("rst_data", 64'(out_data[i]), 64'd0);
      chk("rst_addr", 64'(out_address[i]), 64'd0);
    end
`ifdef PIXEL_COUNT_EN
    chk("rst_count", 64'(covered_count), 64'd0);
`endif
    reset = 1'b0;

    // Full coverage of the screen
    run_job("full", -1, 0, 0, 1'b0);

    // Half plane x >= y
    ea[0] = 1; eb[0] = -1; ec[0] = 0;
    ea[1] = 0; eb[1] = 0;  ec[1] = 1;
    ea[2] = 0; eb[2] = 0;  ec[2] = 1;
    jfb = 32'h0000_0200;
    run_job("xgey", -1, 0, 0, 1'b0);
    chk("xgey_no_px_0_1", 64'(hit[1*SX + 0]), 64'd0);

    // Single row box: only lane 0 active, addresses 26..29
    set_flat(1);
    jx0 = 2; jx1 = 5; jy0 = 3; jy1 = 3;
    jfb = 32'h0;
    run_job("row", -1, 0, 0, 1'b0);
    for (int p = 26; p <= 29; p++) chk("row_addr_hit", 64'(hit[p]), 64'd1);

    // Empty box
    jx0 = 6; jx1 = 2; jy0 = 0; jy1 = 7;
    run_job("empty", -1, 0, 0, 1'b0);

    // Lane 2 back-pressured for 5 cycles mid scan
    jx0 = 0; jx1 = 7; jy0 = 0; jy1 = 7;
    jfb = 32'h0000_4000;
    run_job("stall", 2, 6, 5, 1'b0);

    // Reset in the middle of a scan, then a clean full job
    apply_job();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    run_job("after_rst", -1, 0, 0, 1'b0);

    // Randomized triangles, boxes and back-pressure
    for (int n = 0; n < 14; n++) begin
      for (int k = 0; k < 3; k++) begin
        ea[k] = int'($urandom_range(0, 8)) - 4;
        eb[k] = int'($urandom_range(0, 8)) - 4;
        ec[k] = int'($urandom_range(0, 40)) - 20;
      end
      jx0 = int'($urandom_range(0, 8));
      jx1 = int'($urandom_range(0, 12));
      jy0 = int'($urandom_range(0, 8));
      jy1 = int'($urandom_range(0, 12));
      jfb = $urandom;
      jcol = COLW'($urandom);
      run_job("rand", -1, 0, 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
